// File: rtl/axi_sram_responder.sv
// AXI4-Lite responder in front of a 512x45 single-port SRAM macro; partial writes use read-modify-write.
// Optional byte parity in bits [35:32] is enabled by defining SRAM_PARITY_EN.
module axi_sram_responder #(
  parameter int DEPTH  = 512,
  parameter int IDX_W  = 9,
  parameter int SRAM_W = 45,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_axi_awvalid,
  output logic              mem_axi_awready,
  input  logic [31:0]       mem_axi_awaddr,
  input  logic              mem_axi_wvalid,
  output logic              mem_axi_wready,
  input  logic [DATA_W-1:0] mem_axi_wdata,
  input  logic [3:0]        mem_axi_wstrb,
  output logic              mem_axi_bvalid,
  input  logic              mem_axi_bready,
  output logic [1:0]        mem_axi_bresp,
  input  logic              mem_axi_arvalid,
  output logic              mem_axi_arready,
  input  logic [31:0]       mem_axi_araddr,
  output logic              mem_axi_rvalid,
  input  logic              mem_axi_rready,
  output logic [DATA_W-1:0] mem_axi_rdata,
  output logic [1:0]        mem_axi_rresp,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [IDX_W-1:0]  sram_addr,
  output logic [SRAM_W-1:0] sram_wdata,
  input  logic [SRAM_W-1:0] sram_rdata
);

  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;
  localparam logic [IDX_W-1:0] IDX_MASK    = IDX_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_CAP, RD_RESP, WR_FULL, WR_RMW_RD, WR_MERGE, WR_RESP
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  wdata_q, rdata_q, merged;
  logic [3:0]         wstrb_q;
  logic [1:0]         rresp_q, bresp_q;
  logic               wr_pair, wr_hs, rd_hs, par_err;
  logic               unused_bits;

  assign wr_pair = mem_axi_awvalid & mem_axi_wvalid;
  assign wr_hs   = (state == IDLE) & wr_pair;
  assign rd_hs   = (state == IDLE) & mem_axi_arvalid & ~wr_pair;

`ifdef SRAM_PARITY_EN
  function automatic logic [3:0] byte_par(input logic [DATA_W-1:0] d);
    logic [3:0] p;
    for (int b = 0; b < 4; b++) p[b] = ^d[8*b +: 8];
    return p;
  endfunction

  function automatic logic [SRAM_W-1:0] encode(input logic [DATA_W-1:0] d);
    return {{(SRAM_W-DATA_W-4){1'b0}}, byte_par(d), d};
  endfunction

  assign par_err     = byte_par(sram_rdata[DATA_W-1:0]) != sram_rdata[DATA_W+3:DATA_W];
  assign unused_bits = ^{mem_axi_awaddr[31:IDX_W+2], mem_axi_awaddr[1:0],
                         mem_axi_araddr[31:IDX_W+2], mem_axi_araddr[1:0],
                         sram_rdata[SRAM_W-1:DATA_W+4]};
`else
  function automatic logic [SRAM_W-1:0] encode(input logic [DATA_W-1:0] d);
    return {{(SRAM_W-DATA_W){1'b0}}, d};
  endfunction

  assign par_err     = 1'b0;
  assign unused_bits = ^{mem_axi_awaddr[31:IDX_W+2], mem_axi_awaddr[1:0],
                         mem_axi_araddr[31:IDX_W+2], mem_axi_araddr[1:0],
                         sram_rdata[SRAM_W-1:DATA_W]};
`endif

  // Unstrobed bytes come from the word read back in WR_RMW_RD.
  always_comb begin
    merged = '0;
    for (int b = 0; b < 4; b++)
      merged[8*b +: 8] = wstrb_q[b] ? wdata_q[8*b +: 8] : sram_rdata[8*b +: 8];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_hs)      state_nxt = (mem_axi_wstrb == 4'hF) ? WR_FULL : WR_RMW_RD;
        else if (rd_hs) state_nxt = RD_ISSUE;
      end
      RD_ISSUE:  state_nxt = RD_CAP;
      RD_CAP:    state_nxt = RD_RESP;
      RD_RESP:   if (mem_axi_rready) state_nxt = IDLE;
      WR_FULL:   state_nxt = WR_RESP;
      WR_RMW_RD: state_nxt = WR_MERGE;
      WR_MERGE:  state_nxt = WR_RESP;
      WR_RESP:   if (mem_axi_bready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      bresp_q <= RESP_OKAY;
    end else begin
      if (wr_hs) begin
        idx_q   <= mem_axi_awaddr[IDX_W+1:2] & IDX_MASK;
        wdata_q <= mem_axi_wdata;
        wstrb_q <= mem_axi_wstrb;
        bresp_q <= RESP_OKAY;
      end else if (rd_hs) begin
        idx_q   <= mem_axi_araddr[IDX_W+1:2] & IDX_MASK;
      end
      if (state == RD_CAP) begin
        rdata_q <= sram_rdata[DATA_W-1:0];
        rresp_q <= par_err ? RESP_SLVERR : RESP_OKAY;
      end
      if (state == WR_MERGE)
        bresp_q <= par_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_comb begin
    mem_axi_awready = wr_hs;
    mem_axi_wready  = wr_hs;
    mem_axi_arready = rd_hs;
    mem_axi_rvalid  = (state == RD_RESP);
    mem_axi_bvalid  = (state == WR_RESP);
    mem_axi_rdata   = rdata_q;
    mem_axi_rresp   = rresp_q;
    mem_axi_bresp   = bresp_q;
    sram_addr       = idx_q;
    sram_ce         = 1'b0;
    sram_we         = 1'b0;
    sram_wdata      = '0;
    case (state)
      RD_ISSUE, WR_RMW_RD: sram_ce = 1'b1;
      WR_FULL: begin
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_wdata = encode(wdata_q);
      end
      WR_MERGE: begin
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_wdata = encode(merged);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Bench for axi_sram_responder: SRAM macro model, transaction-level reference model and
// per-cycle compare process, driven by directed transactions.
module tb_axi_sram_responder;

`ifdef SRAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0, resetn = 1'b0;
  logic        mem_axi_awvalid = 0, mem_axi_wvalid = 0, mem_axi_bready = 0;
  logic        mem_axi_arvalid = 0, mem_axi_rready = 0;
  logic [31:0] mem_axi_awaddr = 0, mem_axi_wdata = 0, mem_axi_araddr = 0;
  logic [3:0]  mem_axi_wstrb = 0;
  logic        mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready, mem_axi_rvalid;
  logic [1:0]  mem_axi_bresp, mem_axi_rresp;
  logic [31:0] mem_axi_rdata;
  logic        sram_ce, sram_we;
  logic [8:0]  sram_addr;
  logic [44:0] sram_wdata, sram_rdata;

  axi_sram_responder dut (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready), .mem_axi_awaddr(mem_axi_awaddr),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready), .mem_axi_wdata(mem_axi_wdata),
    .mem_axi_wstrb(mem_axi_wstrb), .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_bresp(mem_axi_bresp), .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata), .mem_axi_rresp(mem_axi_rresp),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  int rd_cnt = 0, wr_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [44:0] enc(input logic [31:0] d);
    if (PAR) return {9'b0, ^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0], d};
    return {13'b0, d};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  // SRAM macro model: one-cycle read latency, whole-word writes.
  logic [44:0] mem [512];
  initial for (int i = 0; i < 512; i++) mem[i] = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sram_ce) begin
      if (sram_we) begin mem[sram_addr] <= sram_wdata; wr_cnt <= wr_cnt + 1; end
      else begin sram_rdata <= mem[sram_addr]; rd_cnt <= rd_cnt + 1; end
    end
  end

  // Reference model: contents per word, plus a flag for a stored parity that no longer matches.
  logic [31:0] ref_mem [512];
  bit          mism [512];
  initial for (int i = 0; i < 512; i++) begin ref_mem[i] = '0; mism[i] = 0; end

  bit          busy = 0, is_wr = 0;
  int          hs = 0, due = 0;
  logic [8:0]  m_idx = 0;
  logic [31:0] m_wd = 0, m_rd = 0;
  logic [3:0]  m_ws = 0;
  logic [1:0]  m_rresp = 0, m_bresp = 0;

  always @(negedge clk) begin
    bit was_busy;
    if (!resetn) busy = 0;
    else begin
      chk("awready", mem_axi_awready, !busy && mem_axi_awvalid && mem_axi_wvalid);
      chk("wready", mem_axi_wready, !busy && mem_axi_awvalid && mem_axi_wvalid);
      chk("arready", mem_axi_arready, !busy && mem_axi_arvalid && !(mem_axi_awvalid && mem_axi_wvalid));
      chk("rvalid", mem_axi_rvalid, busy && !is_wr && cyc >= due);
      chk("bvalid", mem_axi_bvalid, busy && is_wr && cyc >= due);
      if (mem_axi_rvalid) begin chk("rdata", mem_axi_rdata, m_rd); chk("rresp", mem_axi_rresp, m_rresp); end
      if (mem_axi_bvalid) chk("bresp", mem_axi_bresp, m_bresp);
      chk("sram_ce", sram_ce, busy && cyc > hs && cyc < (is_wr ? due : hs + 2));
      chk("sram_we", sram_we, busy && is_wr && cyc == due - 1);
      if (sram_ce) chk("sram_addr", sram_addr, m_idx);
      if (sram_ce && sram_we) chk("sram_wdata", sram_wdata, enc(merge(ref_mem[m_idx], m_wd, m_ws)));
      was_busy = busy;
      if (busy && !is_wr && mem_axi_rvalid && mem_axi_rready) busy = 0;
      if (busy && is_wr && mem_axi_bvalid && mem_axi_bready) begin
        ref_mem[m_idx] = merge(ref_mem[m_idx], m_wd, m_ws);
        mism[m_idx] = 0;
        busy = 0;
      end
      if (!was_busy && mem_axi_awvalid && mem_axi_wvalid) begin
        busy = 1; is_wr = 1; hs = cyc; m_idx = mem_axi_awaddr[10:2];
        m_wd = mem_axi_wdata; m_ws = mem_axi_wstrb;
        due = (m_ws == 4'hF) ? hs + 2 : hs + 3;
        m_bresp = (PAR && m_ws != 4'hF && mism[m_idx]) ? 2'b10 : 2'b00;
      end else if (!was_busy && mem_axi_arvalid) begin
        busy = 1; is_wr = 0; hs = cyc; m_idx = mem_axi_araddr[10:2]; due = hs + 3;
        m_rd = ref_mem[m_idx];
        m_rresp = (PAR && mism[m_idx]) ? 2'b10 : 2'b00;
      end
    end
  end

  // sel: 0 awready, 1 bvalid, 2 arready, 3 rvalid
  task automatic wait_neg(input int sel, output int at);
    bit ok = 0;
    at = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((sel == 0 && mem_axi_awready) || (sel == 1 && mem_axi_bvalid) ||
          (sel == 2 && mem_axi_arready) || (sel == 3 && mem_axi_rvalid)) begin
        ok = 1; at = cyc; break;
      end
    end
    chk($sformatf("wait_%0d_timeout", sel), ok, 1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    int t0, t1;
    @(posedge clk); #1;
    mem_axi_awvalid = 1; mem_axi_wvalid = 1; mem_axi_awaddr = a; mem_axi_wdata = d; mem_axi_wstrb = s;
    wait_neg(0, t0);
    @(posedge clk); #1; mem_axi_awvalid = 0; mem_axi_wvalid = 0;
    wait_neg(1, t1);
    resp = mem_axi_bresp; lat = t1 - t0;
    @(posedge clk); #1; mem_axi_bready = 1;
    @(posedge clk); #1; mem_axi_bready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                         output logic [1:0] resp, output int lat);
    int t0, t1;
    @(posedge clk); #1; mem_axi_arvalid = 1; mem_axi_araddr = a;
    wait_neg(2, t0);
    @(posedge clk); #1; mem_axi_arvalid = 0;
    wait_neg(3, t1);
    d = mem_axi_rdata; resp = mem_axi_rresp; lat = t1 - t0;
    if (hold > 0) begin
      @(posedge clk); #1;
      mem_axi_awvalid = 1; mem_axi_wvalid = 1; mem_axi_arvalid = 1;
      mem_axi_awaddr = 32'h40; mem_axi_wdata = 32'h0BAD0BAD; mem_axi_wstrb = 4'hF; mem_axi_araddr = 32'h44;
      repeat (hold) @(negedge clk);
      chk("hold_rdata_end", mem_axi_rdata, d);
      @(posedge clk); #1; mem_axi_awvalid = 0; mem_axi_wvalid = 0; mem_axi_arvalid = 0;
    end
    @(posedge clk); #1; mem_axi_rready = 1;
    @(posedge clk); #1; mem_axi_rready = 0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat, rc, wc, t0, t1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {mem_axi_awready, mem_axi_wready, mem_axi_arready, mem_axi_rvalid, mem_axi_bvalid,
                       mem_axi_bresp, mem_axi_rresp, sram_ce, sram_we, sram_addr}, 0);
    chk("reset_rdata", mem_axi_rdata, 0);
    chk("reset_sram_wdata", sram_wdata, 0);
    @(posedge clk); #1; resetn = 1;

    do_write(32'h10, 32'hDEADBEEF, 4'hF, r, lat);
    chk("full_w_blat", lat, 2);
    chk("full_w_bresp", r, 0);
    do_read(32'h10, 0, d, r, lat);
    chk("full_r_data", d, 32'hDEADBEEF);
    chk("full_r_lat", lat, 3);
    chk("full_r_resp", r, 0);

    do_write(32'h14, 32'h11223344, 4'hF, r, lat);
    rc = rd_cnt; wc = wr_cnt;
    do_write(32'h14, 32'hAABBCCDD, 4'b0101, r, lat);
    chk("rmw_blat", lat, 3);
    chk("rmw_rd_cycles", rd_cnt - rc, 1);
    chk("rmw_wr_cycles", wr_cnt - wc, 1);
    do_read(32'h14, 0, d, r, lat);
    chk("rmw_data", d, 32'h11BB33DD);

    @(posedge clk); #1;
    mem_axi_awvalid = 1; mem_axi_wvalid = 1; mem_axi_awaddr = 32'h20; mem_axi_wdata = 32'hCAFEF00D;
    mem_axi_wstrb = 4'hF; mem_axi_arvalid = 1; mem_axi_araddr = 32'h20;
    @(negedge clk);
    chk("collide_awready", mem_axi_awready, 1);
    chk("collide_arready", mem_axi_arready, 0);
    @(posedge clk); #1; mem_axi_awvalid = 0; mem_axi_wvalid = 0;
    wait_neg(1, t1);
    @(posedge clk); #1; mem_axi_bready = 1;
    @(posedge clk); #1; mem_axi_bready = 0;
    wait_neg(2, t0);
    @(posedge clk); #1; mem_axi_arvalid = 0;
    wait_neg(3, t1);
    chk("collide_rdata", mem_axi_rdata, 32'hCAFEF00D);
    chk("collide_rlat", t1 - t0, 3);
    @(posedge clk); #1; mem_axi_rready = 1;
    @(posedge clk); #1; mem_axi_rready = 0;

    rc = rd_cnt; wc = wr_cnt;
    do_read(32'h14, 10, d, r, lat);
    chk("hold_data", d, 32'h11BB33DD);
    chk("hold_sram_quiet", (rd_cnt - rc) + (wr_cnt - wc), 1);

    do_write(32'h0000_0800, 32'h5A5A5A5A, 4'hF, r, lat);
    do_read(32'h0, 0, d, r, lat);
    chk("wrap_data", d, 32'h5A5A5A5A);

    @(posedge clk); #1;
    mem_axi_awvalid = 1; mem_axi_wvalid = 1; mem_axi_awaddr = 32'h0; mem_axi_wdata = 32'h0;
    mem_axi_wstrb = 4'b0011;
    wait_neg(0, t0);
    @(posedge clk); #1; mem_axi_awvalid = 0; mem_axi_wvalid = 0;
    chk("abort_ce_before", sram_ce, 1);
    #2; resetn = 0; #1;
    chk("abort_outs", {sram_ce, sram_we, sram_wdata, mem_axi_bvalid, mem_axi_rvalid}, 0);
    wc = wr_cnt;
    repeat (3) @(posedge clk);
    #1; resetn = 1;
    repeat (3) @(posedge clk);
    chk("abort_no_write", wr_cnt - wc, 0);
    do_read(32'h0, 0, d, r, lat);
    chk("abort_word_kept", d, 32'h5A5A5A5A);

    @(posedge clk); #1;
    mem[5][32] = ~mem[5][32];
    mism[5] = ~mism[5];
    do_read(32'h14, 0, d, r, lat);
    chk("par_read_data", d, 32'h11BB33DD);
    chk("par_read_resp", r, PAR ? 2'b10 : 2'b00);
    do_write(32'h14, 32'hFFFFFFFF, 4'h0, r, lat);
    chk("par_rmw_bresp", r, PAR ? 2'b10 : 2'b00);
    do_read(32'h14, 0, d, r, lat);
    chk("par_fixed_data", d, 32'h11BB33DD);
    chk("par_fixed_resp", r, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
